// File: rtl/wave_capture_ctrl.sv
// Oscilloscope-style capture sequencer for the OLED waveform buffer: decimates mic
// samples, runs rolling or single-shot triggered capture, and serves chronological reads.
module wave_capture_ctrl #(
  parameter int DEPTH    = 96,
  parameter int SAMPLE_W = 12,
  parameter int DIV_W    = 16,
  parameter int PRE_TRIG = 48
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sample_tick,
  input  logic [SAMPLE_W-1:0] i_mic_in,
  input  logic [DIV_W-1:0]    i_div,
  input  logic                i_freeze,
  input  logic                i_trig_en,
  input  logic                i_arm,
  input  logic [SAMPLE_W-1:0] i_trig_level,
  input  logic [6:0]          i_rd_x,
  output logic [SAMPLE_W-1:0] o_rd_data,
  output logic [2:0]          o_state,
  output logic                o_frame_done
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int POST_LEN = DEPTH - PRE_TRIG;

  typedef enum logic [2:0] {
    ROLL      = 3'd0,
    FILL_PRE  = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_seg_cnt;
  logic [CNT_W-1:0]     w_seg_next;
  logic [CNT_W-1:0]     w_seg_inc;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_fill_cnt;
  logic [SAMPLE_W-1:0]  r_prev;
  logic [SAMPLE_W-1:0]  r_mem [DEPTH];
  logic [SAMPLE_W-1:0]  r_rd_data;
  logic                 r_frame_done;
  logic                 w_enter_hold;
  logic                 w_take;
  logic                 w_wr;
  logic                 w_cross;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_rd_idx;
  logic                 w_rd_valid;

  // The decimator keeps counting in HOLD; only the buffer write is suppressed there.
  assign w_take    = i_sample_tick && !i_freeze && (r_div_cnt == '0);
  assign w_wr      = w_take && (r_state != HOLD);
  assign w_cross   = (r_prev < i_trig_level) && (i_mic_in >= i_trig_level);
  assign w_seg_inc = r_seg_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (i_sample_tick && !i_freeze) begin
      r_div_cnt <= (r_div_cnt == '0) ? i_div : r_div_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_prev     <= '0;
    end else if (w_wr) begin
      r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (r_fill_cnt != CNT_W'(DEPTH)) begin
        r_fill_cnt <= r_fill_cnt + CNT_W'(1);
      end
      r_prev <= i_mic_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_mic_in;
    end
  end

  // Column 0 maps to the oldest entry, which is the slot the next write will overwrite.
  assign w_sum      = (PTR_W+1)'(r_wr_ptr) + (PTR_W+1)'(i_rd_x);
  assign w_rd_idx   = (w_sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(w_sum - (PTR_W+1)'(DEPTH))
                                                   : PTR_W'(w_sum);
  assign w_rd_valid = (int'(i_rd_x) < DEPTH) && (int'(i_rd_x) >= DEPTH - int'(r_fill_cnt));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_valid ? r_mem[w_rd_idx] : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ROLL;
      r_seg_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_seg_cnt    <= w_seg_next;
      r_frame_done <= w_enter_hold;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_seg_next   = r_seg_cnt;
    w_enter_hold = 1'b0;
    if (!i_trig_en) begin
      w_state_next = ROLL;
    end else if (r_state == ROLL || i_arm) begin
      w_state_next = FILL_PRE;
      w_seg_next   = '0;
    end else begin
      case (r_state)
        FILL_PRE: begin
          if (w_wr) begin
            w_seg_next = w_seg_inc;
            if (w_seg_inc == CNT_W'(PRE_TRIG)) begin
              w_state_next = WAIT_TRIG;
            end
          end
        end
        WAIT_TRIG: begin
          if (w_wr && w_cross) begin
            w_seg_next   = CNT_W'(1);
            w_state_next = (POST_LEN == 1) ? HOLD : POST;
            w_enter_hold = (POST_LEN == 1);
          end
        end
        POST: begin
          if (w_wr) begin
            w_seg_next = w_seg_inc;
            if (w_seg_inc == CNT_W'(POST_LEN)) begin
              w_state_next = HOLD;
              w_enter_hold = 1'b1;
            end
          end
        end
        HOLD: begin
        end
        default: begin
          w_state_next = ROLL;
        end
      endcase
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_state      = r_state;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
- Sequences sample capture into the 96-column waveform buffer that feeds the OLED waveform renderer.
- Decimates the mic sample stream and runs an oscilloscope-style capture state machine: rolling, or single-shot rising-edge trigger with pre-trigger history.
- Serves the renderer a registered, chronologically ordered read port indexed by screen column.

Parameters:
DEPTH, 96, buffer entries, equal to the OLED column count
SAMPLE_W, 12, mic sample width
DIV_W, 16, decimation divider width
PRE_TRIG, 48, samples kept before the trigger sample; range 1..DEPTH-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle pulse when mic_in holds a new sample
mic_in  in  SAMPLE_W  mic sample
div  in  DIV_W  accept 1 of every div+1 ticks
freeze  in  1  level; blocks writes and holds all counters
trig_en  in  1  level; 0 = rolling mode, 1 = triggered mode
arm  in  1  one-cycle pulse; re-arms the trigger
trig_level  in  SAMPLE_W  trigger threshold
rd_x  in  7  screen column to read
rd_data  out  SAMPLE_W  sample for rd_x, registered
state  out  3  ROLL=0, FILL_PRE=1, WAIT_TRIG=2, POST=3, HOLD=4
frame_done  out  1  one-cycle pulse on entry to HOLD

Behaviour:
- Reset (async, rst_n=0): state=ROLL, wr_ptr=0, fill_cnt=0, div_cnt=0, seg_cnt=0, prev=0, rd_data=0, frame_done=0. Memory contents are not cleared; fill_cnt masks them.
- Decimator: when freeze=0 and sample_tick=1, if div_cnt==0 the tick is accepted and div_cnt<=div, else div_cnt<=div_cnt-1. div=0 accepts every tick. A new div value takes effect at the next reload.
- Accepted sample: written at the same edge to mem[wr_ptr]. wr_ptr wraps DEPTH-1 -> 0. fill_cnt saturates at DEPTH. prev<=mic_in.
- freeze=1: no accepts, no writes, and div_cnt/seg_cnt/prev are held. State transitions caused by trig_en or arm still occur.
- Writes are enabled in ROLL, FILL_PRE, WAIT_TRIG and POST, and never in HOLD.
- Transitions, in priority order:
  - trig_en=0 -> ROLL from any state.
  - ROLL with trig_en=1 -> FILL_PRE, seg_cnt<=0.
  - arm=1 in any triggered state -> FILL_PRE, seg_cnt<=0. An accept in that same cycle is written but not counted.
  - FILL_PRE: each accept increments seg_cnt. The accept that makes seg_cnt reach PRE_TRIG moves to WAIT_TRIG, and that sample is not a trigger candidate.
  - WAIT_TRIG: an accept with prev<trig_level and mic_in>=trig_level (unsigned) is the trigger sample. It moves to POST with seg_cnt<=1. A non-crossing accept stays in WAIT_TRIG, overwriting the oldest entries.
  - POST: each accept increments seg_cnt. The accept making seg_cnt reach DEPTH-PRE_TRIG moves to HOLD; frame_done=1 on the following cycle only.
  - HOLD: stays until arm or trig_en=0.
- Read mapping: rd_data <= (rd_x>=DEPTH) ? 0 : (rd_x < DEPTH-fill_cnt) ? 0 : mem[(wr_ptr+rd_x) mod DEPTH]. The modulo is computed without a divider (sum minus DEPTH if >=DEPTH).
  - Latency is one cycle.
  - Read-before-write: a read and write in the same cycle returns the pre-edge pointer and contents.
  - Column 0 is the oldest sample and column DEPTH-1 the newest.
  - In HOLD the trigger sample sits at column PRE_TRIG.
- Reset mid-capture returns to ROLL; trig_en still high then re-enters FILL_PRE one cycle after release.

Test Plan:
- Reset then ROLL, div=0, 100 ticks with mic_in=tick index 1..100 -> rd_x=0 reads 5, rd_x=95 reads 100 one cycle later. Before any tick, every column reads 0.
- div=3, 16 ticks of values 1..16 -> samples 1, 5, 9, 13 accepted. The first accept is immediate after reset; fill_cnt=4; rd_x=92..95 read 1, 5, 9, 13.
- trig_en=1, trig_level=2048, ramp 0..4095 step 64 per tick -> state goes 1, 2, 3, 4. frame_done pulses once. In HOLD, rd_x=48 reads 2048, rd_x=47 reads 1984, and further ticks change nothing.
- Trigger candidacy: a crossing on the 48th FILL_PRE sample does not trigger. The next crossing (prev=100, cur=3000, level=2048) triggers.
- freeze=1 during POST for 50 ticks -> seg_cnt, wr_ptr and memory unchanged. After release the capture completes with exactly DEPTH-PRE_TRIG post samples.
- arm pulse in HOLD -> FILL_PRE next cycle. trig_en=0 and arm in the same cycle -> ROLL. Async rst_n low mid-POST -> state=0 and rd_data=0 immediately.
